lfsr_gen: RTL

LFSR_GEN -- requirements
Module: lfsr_gen

---
 rtl/lfsr_gen.sv | 94 +++++++++
 1 files changed

// File: rtl/lfsr_gen.sv
// Configurable Fibonacci/Galois LFSR with period measurement and lock-up guard.
// The reference state marks the start of a period; returning to it measures the period length.
module lfsr_gen #(
    parameter int               WIDTH        = 5,
    parameter logic [WIDTH-1:0] FIB_TAPS     = 5'b10100,
    parameter logic [WIDTH-1:0] GAL_TAPS     = 5'b01001,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 5'b00001
) (
    input  logic             clkTop,
    input  logic             nrstTop,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic             out_bit,
    output logic [WIDTH-1:0] state,
    output logic             period_wrap,
    output logic [WIDTH-1:0] period_len,
    output logic             period_ovf,
    output logic             lockup_err
);

    logic [WIDTH-1:0] refState;
    logic [WIDTH-1:0] cnt;
    logic             modeQ;
    logic [WIDTH-1:0] fibNext;
    logic [WIDTH-1:0] galNext;
    logic [WIDTH-1:0] stepNext;

    always_comb begin
        fibNext  = {state[WIDTH-2:0], ^(state & FIB_TAPS)};
        galNext  = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? GAL_TAPS : '0);
        stepNext = mode ? galNext : fibNext;
    end

    assign out_bit = state[WIDTH-1];

    always_ff @(posedge clkTop) begin
        if (!nrstTop) begin
            state       <= DEFAULT_SEED;
            refState    <= DEFAULT_SEED;
            cnt         <= '0;
            period_len  <= '0;
            period_wrap <= 1'b0;
            period_ovf  <= 1'b0;
            lockup_err  <= 1'b0;
            modeQ       <= mode;
        end else begin
            period_wrap <= 1'b0;
            lockup_err  <= 1'b0;
            modeQ       <= mode;
            if (load) begin
                if (seed == '0) begin
                    state      <= DEFAULT_SEED;
                    refState   <= DEFAULT_SEED;
                    lockup_err <= 1'b1;
                end else begin
                    state    <= seed;
                    refState <= seed;
                end
                cnt        <= '0;
                period_ovf <= 1'b0;
            end else if (en && state == '0) begin
                state      <= DEFAULT_SEED;
                refState   <= DEFAULT_SEED;
                cnt        <= '0;
                lockup_err <= 1'b1;
            end else if (mode != modeQ) begin
                // A mode switch starts a fresh period from wherever the register lands.
                if (en) begin
                    state    <= stepNext;
                    refState <= stepNext;
                end else begin
                    refState <= state;
                end
                cnt <= '0;
            end else if (en) begin
                state <= stepNext;
                if (stepNext == refState) begin
                    period_len  <= cnt + 1'b1;
                    cnt         <= '0;
                    period_wrap <= 1'b1;
                end else if (cnt == '1) begin
                    period_ovf <= 1'b1;
                    refState   <= stepNext;
                    cnt        <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule
